cmos_gate_driver: RTL and testbench

- Multi-channel complementary gate driver: generalises the single CMOS inverter stage.
- The pull-up (PMOS-side) and pull-down (NMOS-side) enables are driven separately.
- Break-before-make dead time is enforced, so both sides are never on in the same cycle.
- Each channel can invert or pass its input, and drives a tri-stated output pin model.
- Sits between digital control logic and output-stage / pad models.

---
 rtl/cmos_gate_driver_pkg.sv | 27 ++
 rtl/gate_drive_channel.sv | 95 +++++++++
 rtl/cmos_gate_driver.sv | 41 ++++
 tb/tb_cmos_gate_driver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_gate_driver_pkg.sv
// Shared types for the complementary gate driver: per-channel drive state
// encoding, default dead-time field width and the drive-target decision.
package cmos_gate_driver_pkg;

  localparam int DTW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2,
    ST_DEAD = 2'd3
  } drive_state_e;

  // Side a channel wants to drive given its enable and desired level.
  function automatic drive_state_e drive_target(input logic en, input logic d);
    drive_state_e tgt;
    if (!en) begin
      tgt = ST_OFF;
    end else if (d) begin
      tgt = ST_UP;
    end else begin
      tgt = ST_DN;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/gate_drive_channel.sv
// Single complementary drive channel: break-before-make FSM with a dead-time
// counter, registered pull-up/pull-down enables and a tri-stated pin model.
module gate_drive_channel
  import cmos_gate_driver_pkg::*;
#(
  parameter int DTW = DTW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           d,
  input  logic [DTW-1:0] dead_cfg,
  output logic           pu_on,
  output logic           pd_on,
  output wire            y,
  output logic           busy
);

  drive_state_e   state_r;
  drive_state_e   state_nxt_s;
  logic [DTW-1:0] cnt_r;
  logic [DTW-1:0] cnt_nxt_s;
  logic [DTW-1:0] dead_load_s;
  logic           pu_on_r;
  logic           pd_on_r;
  logic           busy_r;

  // A zero dead-time setting still guarantees one fully-off cycle.
  assign dead_load_s = (dead_cfg == {DTW{1'b0}}) ? DTW'(1) : dead_cfg;

  // Next-state and dead-counter decision.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_OFF: begin
        state_nxt_s = drive_target(en, d);
      end
      ST_UP: begin
        if (!en || !d) begin
          state_nxt_s = ST_DEAD;
          cnt_nxt_s   = dead_load_s;
        end else begin
          state_nxt_s = ST_UP;
        end
      end
      ST_DN: begin
        if (!en || d) begin
          state_nxt_s = ST_DEAD;
          cnt_nxt_s   = dead_load_s;
        end else begin
          state_nxt_s = ST_DN;
        end
      end
      ST_DEAD: begin
        // Only the exit edge looks at the inputs; the length is fixed at entry.
        if (cnt_r <= DTW'(1)) begin
          state_nxt_s = drive_target(en, d);
          cnt_nxt_s   = {DTW{1'b0}};
        end else begin
          state_nxt_s = ST_DEAD;
          cnt_nxt_s   = cnt_r - DTW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_OFF;
        cnt_nxt_s   = {DTW{1'b0}};
      end
    endcase
  end

  // State, counter and outputs registered together so pu_on/pd_on are
  // decoded from a single state value and can never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_OFF;
      cnt_r   <= {DTW{1'b0}};
      pu_on_r <= 1'b0;
      pd_on_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pu_on_r <= (state_nxt_s == ST_UP);
      pd_on_r <= (state_nxt_s == ST_DN);
      busy_r  <= (state_nxt_s == ST_DEAD);
    end
  end

  assign pu_on = pu_on_r;
  assign pd_on = pd_on_r;
  assign busy  = busy_r;
  assign y     = pu_on_r ? 1'b1 : (pd_on_r ? 1'b0 : 1'bz);

endmodule

// File: rtl/cmos_gate_driver.sv
// Multi-channel complementary gate driver: per-channel polarity select
// feeding independent break-before-make drive channels.
module cmos_gate_driver
  import cmos_gate_driver_pkg::*;
#(
  parameter int            CH       = 4,
  parameter int            DTW      = DTW_DEFAULT,
  parameter logic [CH-1:0] INV_MASK = {CH{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  en,
  input  logic [CH-1:0]  in,
  input  logic [DTW-1:0] dead_cfg,
  output logic [CH-1:0]  pu_on,
  output logic [CH-1:0]  pd_on,
  output wire  [CH-1:0]  y,
  output logic [CH-1:0]  busy
);

  logic [CH-1:0] d_s;

  assign d_s = in ^ INV_MASK;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    gate_drive_channel #(
      .DTW(DTW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .d        (d_s[i]),
      .dead_cfg (dead_cfg),
      .pu_on    (pu_on[i]),
      .pd_on    (pd_on[i]),
      .y        (y[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_cmos_gate_driver.sv
// Self-checking bench for cmos_gate_driver: an inverting and a mixed-polarity
// instance share stimulus and are compared against a behavioural model.
module tb_cmos_gate_driver;

  localparam int            CH    = 4;
  localparam int            DTW   = 4;
  localparam logic [CH-1:0] MASK0 = 4'b1111;
  localparam logic [CH-1:0] MASK1 = 4'b0101;

  logic           clk = 1'b0;
  logic           rst;
  logic [CH-1:0]  en;
  logic [CH-1:0]  din;
  logic [DTW-1:0] dead_cfg;
  logic [CH-1:0]  pu0, pd0, busy0, pu1, pd1, busy1;
  wire  [CH-1:0]  y0, y1;

  int checks = 0;
  int errors = 0;

  // Model: drive side per channel (+1 pull-up, -1 pull-down, 0 off) and
  // remaining dead-time cycles (>0 means both sides held off).
  int m_drv  [2][CH];
  int m_dead [2][CH];

  cmos_gate_driver #(.CH(CH), .DTW(DTW), .INV_MASK(MASK0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in(din), .dead_cfg(dead_cfg),
    .pu_on(pu0), .pd_on(pd0), .y(y0), .busy(busy0)
  );

  cmos_gate_driver #(.CH(CH), .DTW(DTW), .INV_MASK(MASK1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in(din), .dead_cfg(dead_cfg),
    .pu_on(pu1), .pd_on(pd1), .y(y1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] mask_of(input int k);
    return (k == 0) ? MASK0 : MASK1;
  endfunction

  task automatic model_step();
    logic [CH-1:0] mk;
    for (int k = 0; k < 2; k++) begin
      mk = mask_of(k);
      for (int i = 0; i < CH; i++) begin
        int want;
        want = !en[i] ? 0 : ((din[i] ^ mk[i]) ? 1 : -1);
        if (rst) begin
          m_drv[k][i]  = 0;
          m_dead[k][i] = 0;
        end else if (m_dead[k][i] > 0) begin
          if (m_dead[k][i] == 1) begin
            m_drv[k][i]  = want;
            m_dead[k][i] = 0;
          end else begin
            m_dead[k][i] = m_dead[k][i] - 1;
          end
        end else if (m_drv[k][i] != 0 && want != m_drv[k][i]) begin
          m_drv[k][i]  = 0;
          m_dead[k][i] = (dead_cfg == 0) ? 1 : int'(dead_cfg);
        end else begin
          m_drv[k][i] = want;
        end
      end
    end
  endtask

  function automatic logic [CH-1:0] exp_pu(input int k);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_drv[k][i] == 1);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_pd(input int k);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_drv[k][i] == -1);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_busy(input int k);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_dead[k][i] > 0);
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'hF; din = 4'h0; dead_cfg = 4'd0;
    repeat (2) begin
      cycle();
      checks++;
      if ({pu0, pd0, busy0, pu1, pd1, busy1} !== 24'h0) begin
        errors++;
        $display("FAIL reset_outputs got pu0=%b pd0=%b busy0=%b pu1=%b pd1=%b busy1=%b want all 0",
                 pu0, pd0, busy0, pu1, pd1, busy1);
      end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (pu0 !== 4'hF || pd0 !== 4'h0 || y0 !== 4'hF) begin
      errors++;
      $display("FAIL enable_inv got pu0=%b pd0=%b y0=%b want 1111 0000 1111", pu0, pd0, y0);
    end
    checks++;
    if (pu1 !== 4'b0101 || pd1 !== 4'b1010 || y1 !== 4'b0101) begin
      errors++;
      $display("FAIL enable_mixed got pu1=%b pd1=%b y1=%b want 0101 1010 0101", pu1, pd1, y1);
    end
  endtask

  task automatic test_dead_time();
    int cnt;
    dead_cfg = 4'd3;
    din = 4'b0001;
    cycle();
    cnt = 0;
    for (int c = 0; c < 20 && busy0[0]; c++) begin
      cnt++;
      checks++;
      if (pu0[0] !== 1'b0 || pd0[0] !== 1'b0) begin
        errors++;
        $display("FAIL dead_sides_off got pu=%b pd=%b want 0 0", pu0[0], pd0[0]);
      end
      cycle();
    end
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("FAIL dead_len3 got %0d cycles want 3", cnt);
    end
    checks++;
    if (pd0[0] !== 1'b1 || pu0[0] !== 1'b0 || y0[0] !== 1'b0) begin
      errors++;
      $display("FAIL dead_exit_dn got pd=%b pu=%b y=%b want 1 0 0", pd0[0], pu0[0], y0[0]);
    end
  endtask

  task automatic test_zero_dead();
    int off;
    dead_cfg = 4'd0;
    din = 4'b0000;
    cycle();
    off = 0;
    for (int c = 0; c < 20 && !pu0[0]; c++) begin
      off++;
      cycle();
    end
    checks++;
    if (off != 1) begin
      errors++;
      $display("FAIL zero_dead got %0d off cycles want 1", off);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] m;
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ~CH'($urandom & $urandom & $urandom);
      din = din ^ CH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) dead_cfg = DTW'($urandom);
      cycle();
      checks++;
      if ((pu0 & pd0) !== 4'h0 || (pu1 & pd1) !== 4'h0) begin
        errors++;
        $display("FAIL overlap n=%0d got pu0&pd0=%b pu1&pd1=%b want 0000", n, pu0 & pd0, pu1 & pd1);
      end
      checks++;
      if ({pu0, pd0, busy0} !== {exp_pu(0), exp_pd(0), exp_busy(0)}) begin
        errors++;
        $display("FAIL rand_dut0 n=%0d got pu=%b pd=%b busy=%b want pu=%b pd=%b busy=%b",
                 n, pu0, pd0, busy0, exp_pu(0), exp_pd(0), exp_busy(0));
      end
      checks++;
      if ({pu1, pd1, busy1} !== {exp_pu(1), exp_pd(1), exp_busy(1)}) begin
        errors++;
        $display("FAIL rand_dut1 n=%0d got pu=%b pd=%b busy=%b want pu=%b pd=%b busy=%b",
                 n, pu1, pd1, busy1, exp_pu(1), exp_pd(1), exp_busy(1));
      end
      m = exp_pu(0) | exp_pd(0);
      checks++;
      if ((y0 & m) !== (exp_pu(0) & m)) begin
        errors++;
        $display("FAIL rand_y0 n=%0d got y=%b want %b on driven bits %b", n, y0, exp_pu(0), m);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_revert();
    int cnt;
    en = 4'hF; din = 4'h0; dead_cfg = 4'd5;
    repeat (20) cycle();
    din = 4'b0010;
    cycle();
    cnt = 0;
    for (int c = 0; c < 30 && busy0[1]; c++) begin
      cnt++;
      if (cnt == 2) din = 4'b0000;
      cycle();
    end
    checks++;
    if (cnt != 5) begin
      errors++;
      $display("FAIL revert_len got %0d cycles want 5", cnt);
    end
    checks++;
    if (pu0[1] !== 1'b1 || pd0[1] !== 1'b0) begin
      errors++;
      $display("FAIL revert_side got pu=%b pd=%b want 1 0", pu0[1], pd0[1]);
    end
  endtask

  task automatic test_disable_reset();
    int cnt;
    en = 4'hF; din = 4'hF; dead_cfg = 4'd2;
    repeat (20) cycle();
    en = 4'b1011;
    cycle();
    cnt = 0;
    for (int c = 0; c < 20 && busy0[2]; c++) begin
      cnt++;
      cycle();
    end
    checks++;
    if (cnt != 2) begin
      errors++;
      $display("FAIL disable_len got %0d cycles want 2", cnt);
    end
    checks++;
    if (pu0[2] !== 1'b0 || pd0[2] !== 1'b0 || pd0[3] !== 1'b1) begin
      errors++;
      $display("FAIL disable_off got pu2=%b pd2=%b pd3=%b want 0 0 1", pu0[2], pd0[2], pd0[3]);
    end
    dead_cfg = 4'd5;
    din = 4'b0111;
    cycle();
    checks++;
    if (busy0[3] !== 1'b1) begin
      errors++;
      $display("FAIL enter_dead got busy3=%b want 1", busy0[3]);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({busy0, pu0, pd0, busy1, pu1, pd1} !== 24'h0) begin
      errors++;
      $display("FAIL reset_in_dead got busy0=%b pu0=%b pd0=%b busy1=%b want all 0", busy0, pu0, pd0, busy1);
    end
  endtask

  task automatic test_buffer_polarity();
    rst = 1'b1; en = 4'hF; din = 4'hF; dead_cfg = 4'd4;
    cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if (y1 !== 4'b1010 || pu1 !== 4'b1010 || pd1 !== 4'b0101) begin
      errors++;
      $display("FAIL buffer_pol got y1=%b pu1=%b pd1=%b want 1010 1010 0101", y1, pu1, pd1);
    end
    din = 4'b0110;
    cycle();
    checks++;
    if (busy1 !== 4'b1001 || busy0 !== 4'b1001 || pu1[1] !== 1'b1 || pd1[2] !== 1'b1) begin
      errors++;
      $display("FAIL pair_dead got busy1=%b busy0=%b pu1=%b pd1=%b want 1001 1001 x1xx xx1x",
               busy1, busy0, pu1, pd1);
    end
    repeat (4) cycle();
    checks++;
    if (busy1 !== 4'b0000 || pu1 !== 4'b0011 || pd1 !== 4'b1100) begin
      errors++;
      $display("FAIL pair_exit got busy1=%b pu1=%b pd1=%b want 0000 0011 1100", busy1, pu1, pd1);
    end
    checks++;
    if ({pu1, pd1, busy1} !== {exp_pu(1), exp_pd(1), exp_busy(1)}) begin
      errors++;
      $display("FAIL pair_model got pu=%b pd=%b busy=%b want pu=%b pd=%b busy=%b",
               pu1, pd1, busy1, exp_pu(1), exp_pd(1), exp_busy(1));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < CH; i++) begin
        m_drv[k][i]  = 0;
        m_dead[k][i] = 0;
      end
    end
    rst = 1'b1; en = 4'h0; din = 4'h0; dead_cfg = 4'd0;
    test_reset();
    test_dead_time();
    test_zero_dead();
    test_random();
    test_revert();
    test_disable_reset();
    test_buffer_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
